// File: rtl/alu_frame_sequencer_if.sv
// Byte-stream command/result bus between a host and alu_frame_sequencer.
// The master modport is the host side; the slave modport is the sequencer.
interface alu_frame_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  res_data,
        input  res_valid,
        output res_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output res_data,
        output res_valid,
        input  res_ready
    );
endinterface

// File: rtl/alu_frame_sequencer.sv
// Byte-serial front end for an external combinational ALU: loads header/A/B,
// holds operands for one execute cycle, then returns the captured result.
module alu_frame_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_frame_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_out,
    output logic [7:0]            op_count
);

    typedef enum logic [2:0] {
        HDR,
        LD_A,
        LD_B,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] last_result;
    logic [WIDTH-1:0] res_data_q;
    logic             res_valid_q;
    logic             beat;

    assign bus.in_ready  = (state == HDR) || (state == LD_A) || (state == LD_B);
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign beat          = bus.in_valid && bus.in_ready;

    // A chained header skips LD_A by substituting the previous result as A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HDR;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= 2'd0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            last_result <= '0;
            op_count    <= 8'd0;
        end else begin
            case (state)
                HDR: begin
                    if (beat) begin
                        alu_sel <= bus.in_data[1:0];
                        if (bus.in_data[2]) begin
                            alu_a <= last_result;
                            state <= LD_B;
                        end else begin
                            state <= LD_A;
                        end
                    end
                end
                LD_A: begin
                    if (beat) begin
                        alu_a <= bus.in_data;
                        state <= LD_B;
                    end
                end
                LD_B: begin
                    if (beat) begin
                        alu_b <= bus.in_data;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= alu_out;
                    last_result <= alu_out;
                    res_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count    <= op_count + 8'd1;
                        state       <= HDR;
                    end
                end
                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed self-checking bench for alu_frame_sequencer with a behavioural ALU.
module tb_alu_frame_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_out;
    logic [7:0] op_count;

    int n_compared;
    int n_mismatched;

    alu_frame_sequencer_if #(.WIDTH(8)) bus ();

    alu_frame_sequencer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: add, subtract, and, or, all modulo 256.
    always_comb begin
        alu_out = 8'h00;
        case (alu_sel)
            2'd0: alu_out = alu_a + alu_b;
            2'd1: alu_out = alu_a - alu_b;
            2'd2: alu_out = alu_a & alu_b;
            2'd3: alu_out = alu_a | alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one byte and returns #1 after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 16'(bus.in_ready), 16'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] hdr, input logic [7:0] a,
                                 input logic [7:0] b);
        send_byte(hdr);
        if (!hdr[2]) send_byte(a);
        send_byte(b);
    endtask

    // Called right after the B beat with res_ready already high.
    task automatic finish_frame(input string tag, input logic [7:0] exp_res,
                                input logic [7:0] exp_cnt);
        checkOutput({tag, "_exec_valid"}, 16'(bus.res_valid), 16'd0);
        checkOutput({tag, "_exec_ready"}, 16'(bus.in_ready), 16'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid"}, 16'(bus.res_valid), 16'd1);
        checkOutput({tag, "_data"}, 16'(bus.res_data), 16'(exp_res));
        @(posedge clk);
        #1;
        checkOutput({tag, "_count"}, 16'(op_count), 16'(exp_cnt));
        checkOutput({tag, "_released"}, 16'(bus.res_valid), 16'd0);
        checkOutput({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        checkOutput({tag, "_res_valid"}, 16'(bus.res_valid), 16'd0);
        checkOutput({tag, "_res_data"}, 16'(bus.res_data), 16'd0);
        checkOutput({tag, "_alu_a"}, 16'(alu_a), 16'd0);
        checkOutput({tag, "_alu_b"}, 16'(alu_b), 16'd0);
        checkOutput({tag, "_alu_sel"}, 16'(alu_sel), 16'd0);
        checkOutput({tag, "_op_count"}, 16'(op_count), 16'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sel_results [4];
    logic [7:0] exp_chain;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        sel_results[0] = 8'h1B;
        sel_results[1] = 8'hF1;
        sel_results[2] = 8'h04;
        sel_results[3] = 8'h17;

        #2;
        check_reset_values("por");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(8'h00, 8'h06, 8'h15);
        finish_frame("add", 8'h1B, 8'd1);

        for (int s = 0; s < 4; s++) begin
            applyStimulus(8'(s), 8'h06, 8'h15);
            finish_frame($sformatf("sel%0d", s), sel_results[s], 8'(2 + s));
        end

        applyStimulus(8'h00, 8'h06, 8'h15);
        finish_frame("chain_base", 8'h1B, 8'd6);
        applyStimulus(8'h05, 8'h00, 8'h03);
        finish_frame("chain_sub", 8'h18, 8'd7);

        pulse_reset("midsim");
        applyStimulus(8'h04, 8'h00, 8'h09);
        finish_frame("chain_after_reset", 8'h09, 8'd1);

        // Result held off for 10 cycles while junk bytes are offered.
        bus.res_ready = 1'b0;
        applyStimulus(8'h03, 8'h0F, 8'hF0);
        @(posedge clk);
        #1;
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("bp_valid%0d", c), 16'(bus.res_valid), 16'd1);
            checkOutput($sformatf("bp_data%0d", c), 16'(bus.res_data), 16'h00FF);
            checkOutput($sformatf("bp_ready%0d", c), 16'(bus.in_ready), 16'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("bp_count_held", 16'(op_count), 16'd1);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp_count", 16'(op_count), 16'd2);
        checkOutput("bp_released", 16'(bus.res_valid), 16'd0);
        checkOutput("bp_sel_kept", 16'(alu_sel), 16'd3);
        checkOutput("bp_a_kept", 16'(alu_a), 16'h000F);
        @(posedge clk);
        #1;
        checkOutput("bp_count_once", 16'(op_count), 16'd2);

        // Stall partway through a frame, then discard it with a reset.
        send_byte(8'h01);
        send_byte(8'h77);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stall_in_ready", 16'(bus.in_ready), 16'd1);
        checkOutput("stall_alu_a", 16'(alu_a), 16'h0077);
        checkOutput("stall_alu_sel", 16'(alu_sel), 16'd1);
        checkOutput("stall_alu_b", 16'(alu_b), 16'h00F0);
        checkOutput("stall_res_valid", 16'(bus.res_valid), 16'd0);
        pulse_reset("stall_reset");
        applyStimulus(8'h02, 8'hF0, 8'h3C);
        finish_frame("post_reset_and", 8'h30, 8'd1);

        // Chained +1 frames until the operation counter wraps.
        exp_chain = 8'h30;
        for (int k = 2; k <= 256; k++) begin
            exp_chain = exp_chain + 8'd1;
            applyStimulus(8'h04, 8'h00, 8'h01);
            finish_frame($sformatf("wrap%0d", k), exp_chain, 8'(k));
        end
        checkOutput("wrap_zero", 16'(op_count), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
